ctl_fsm: RTL and testbench
==========================

# ctl_fsm

Multi-cycle sequencer for the L1 core datapath. It walks each instruction through fetch, decode, execute, memory and writeback. It gates each stage with a one-hot ready strobe and waits on request/response handshakes for instruction and data RAM. It also keeps cycle and retired-instruction counters and halts on EBREAK or a bus timeout. It sits beside the IFU/IDU/EXU/LSU/WBU stages and drives their `i_sys_ready` inputs.

## Interface
- `ARGS_WIDTH`, default `` `ARGS_WIDTH ``: width of decode control fields.
- `TMO_CYCLES`, default 255: maximum wait cycles for a RAM response, range 1..65535.
- `i_clk`  in  1  sole clock, rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_run`  in  1  leave IDLE and begin fetching.
- `i_ifu_rsp_valid`  in  1  instruction RAM returned the word.
- `i_lsu_rsp_valid`  in  1  data RAM completed the load or store.
- `i_ctr_ram_wr_en`  in  1  decoded store.
- `i_ctr_reg_wr_src`  in  `ARGS_WIDTH`  decoded writeback source; `` `REG_WR_SRC_MEM `` marks a load.
- `i_ctr_reg_wr_en`  in  1  decoded GPR write enable.
- `i_inst_ebreak`  in  1  decoded EBREAK.
- `o_ifu_req`  out  1  instruction fetch request, level.
- `o_idu_ready`, `o_exu_ready`, `o_wbu_ready`  out  1 each  stage enables, mutually exclusive.
- `o_lsu_req`  out  1  data access request, level.
- `o_gpr_wr_en`  out  1  GPR commit strobe.
- `o_pc_wr_en`  out  1  PC update strobe.
- `o_halt`  out  1  core stopped.
- `o_err`  out  1  stopped due to timeout.
- `o_cyc_cnt`  out  64  cycles since leaving IDLE.
- `o_ins_cnt`  out  64  retired instructions.

## Operation
- States: IDLE, IF, ID, EX, MA, WB, HALT. State register uses a 3-bit binary encoding.
- IDLE:
  - Goes to IF when `i_run`=1.
  - `i_run` is sampled only in IDLE.
- IF:
  - `o_ifu_req`=1.
  - Goes to ID when `i_ifu_rsp_valid`=1.
- ID: one cycle, `o_idu_ready`=1, then EX.
- EX: one cycle, `o_exu_ready`=1. Next state, in priority order:
  - `i_inst_ebreak`=1 → HALT.
  - `i_ctr_ram_wr_en`=1 or `i_ctr_reg_wr_src`==`` `REG_WR_SRC_MEM `` → MA.
  - Otherwise → WB.
- MA:
  - `o_lsu_req`=1.
  - Goes to WB when `i_lsu_rsp_valid`=1.
- WB: one cycle, then IF.
  - `o_wbu_ready`=1 and `o_pc_wr_en`=1.
  - `o_gpr_wr_en`=`i_ctr_reg_wr_en`.
  - `o_ins_cnt` increments.
- HALT:
  - Absorbing; only reset exits.
  - `o_halt`=1.
  - All strobes and requests are 0.
- Timeout counter, 16-bit:
  - Cleared on entry to IF or MA.
  - Increments each cycle spent waiting in IF or MA without a response.
  - When it equals `TMO_CYCLES` and no response is present: go to HALT with `o_err`=1.
  - A response in the same cycle wins: normal transition, no error.
- `o_cyc_cnt`:
  - Increments every cycle in IF, ID, EX, MA and WB.
  - Frozen in IDLE and HALT.
- Both counters wrap modulo 2^64 with no flag.
- Responses arriving outside IF (for `i_ifu_rsp_valid`) or outside MA (for `i_lsu_rsp_valid`) are ignored.
- All outputs are decoded from registered state and counters; none depend combinationally on inputs except `o_gpr_wr_en`, which is AND-gated by state==WB.

## Timing
- Reset (async assert, sync deassert by the system):
  - State=IDLE.
  - All counters 0.
  - `o_halt`=0, `o_err`=0, all requests and strobes 0.
- Reset asserted mid-instruction: immediate return to IDLE, counters cleared, no strobe glitch beyond the asynchronous clear.
- Minimum instruction latency with zero-wait responses:
  - ALU or branch: IF, ID, EX, WB = 4 cycles.
  - Load/store: 5 cycles.
- Response sampled on the same edge as the request level:
  - `i_ifu_rsp_valid` high in the first IF cycle gives a 1-cycle IF.
  - Each extra wait adds 1 cycle.
- `o_err` and `o_halt` assert in the cycle after the timeout is detected and remain high until reset.

## Test plan
- Reset, then `i_run`=1 pulse, then 3 ALU instructions with immediate responses:
  - IF→ID→EX→WB repeats with a period of 4 cycles.
  - `o_ins_cnt`=3 after 12 cycles; `o_cyc_cnt`=12.
- Load (`i_ctr_reg_wr_src`=MEM) with `i_lsu_rsp_valid` delayed 3 cycles:
  - MA lasts 4 cycles.
  - `o_gpr_wr_en`=1 for exactly one cycle in WB.
- Store with `i_ctr_reg_wr_en`=0:
  - MA entered.
  - WB has `o_pc_wr_en`=1 and `o_gpr_wr_en`=0.
- `i_inst_ebreak`=1 in EX:
  - `o_halt`=1 next cycle; `o_ins_cnt` not incremented.
  - Counters frozen thereafter; `i_run` ignored.
- `TMO_CYCLES`=4, fetch response withheld:
  - HALT with `o_err`=1 after the 5th IF cycle.
  - Repeat with the response arriving on the 4th wait cycle: no error, goes to ID.
- `i_rst_n` pulsed low during MA:
  - All outputs 0 and counters 0 immediately, without waiting for a clock edge.
  - State IDLE after release.

Source files
------------

// File: rtl/ctl_fsm.sv
// Multi-cycle instruction sequencer: steps each instruction through IF/ID/EX/MA/WB,
// waits on RAM handshakes with a bounded timeout, and keeps cycle/retire counters.
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 3
`endif
`ifndef REG_WR_SRC_MEM
`define REG_WR_SRC_MEM 1
`endif

module ctl_fsm #(
    parameter int ARGS_WIDTH = `ARGS_WIDTH,
    parameter int TMO_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_run,
    input  logic                  i_ifu_rsp_valid,
    input  logic                  i_lsu_rsp_valid,
    input  logic                  i_ctr_ram_wr_en,
    input  logic [ARGS_WIDTH-1:0] i_ctr_reg_wr_src,
    input  logic                  i_ctr_reg_wr_en,
    input  logic                  i_inst_ebreak,
    output logic                  o_ifu_req,
    output logic                  o_idu_ready,
    output logic                  o_exu_ready,
    output logic                  o_wbu_ready,
    output logic                  o_lsu_req,
    output logic                  o_gpr_wr_en,
    output logic                  o_pc_wr_en,
    output logic                  o_halt,
    output logic                  o_err,
    output logic [63:0]           o_cyc_cnt,
    output logic [63:0]           o_ins_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MA   = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    localparam logic [15:0]           TMO_LIMIT = 16'(TMO_CYCLES);
    localparam logic [ARGS_WIDTH-1:0] SRC_MEM   = ARGS_WIDTH'(`REG_WR_SRC_MEM);

    state_t      state_reg, state_next;
    logic [15:0] tmo_reg;
    logic        err_next;
    logic        ifu_req_reg, idu_ready_reg, exu_ready_reg, wbu_ready_reg;
    logic        lsu_req_reg, halt_reg, err_reg;
    logic [63:0] cyc_cnt_reg, ins_cnt_reg;
    logic        entering_wait, waiting;

    always_comb begin
        state_next = state_reg;
        err_next   = 1'b0;
        case (state_reg)
            S_IDLE: if (i_run) state_next = S_IF;
            S_IF: begin
                if (i_ifu_rsp_valid) begin
                    state_next = S_ID;
                end else if (tmo_reg == TMO_LIMIT) begin
                    state_next = S_HALT;
                    err_next   = 1'b1;
                end
            end
            S_ID: state_next = S_EX;
            S_EX: begin
                if (i_inst_ebreak)
                    state_next = S_HALT;
                else if (i_ctr_ram_wr_en || (i_ctr_reg_wr_src == SRC_MEM))
                    state_next = S_MA;
                else
                    state_next = S_WB;
            end
            S_MA: begin
                if (i_lsu_rsp_valid) begin
                    state_next = S_WB;
                end else if (tmo_reg == TMO_LIMIT) begin
                    state_next = S_HALT;
                    err_next   = 1'b1;
                end
            end
            S_WB:    state_next = S_IF;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // IF and MA are always left before being re-entered, so a state change marks entry
    assign entering_wait = (state_next != state_reg) && ((state_next == S_IF) || (state_next == S_MA));
    assign waiting       = ((state_reg == S_IF) && !i_ifu_rsp_valid) ||
                           ((state_reg == S_MA) && !i_lsu_rsp_valid);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg     <= S_IDLE;
            tmo_reg       <= 16'd0;
            ifu_req_reg   <= 1'b0;
            idu_ready_reg <= 1'b0;
            exu_ready_reg <= 1'b0;
            wbu_ready_reg <= 1'b0;
            lsu_req_reg   <= 1'b0;
            halt_reg      <= 1'b0;
            err_reg       <= 1'b0;
            cyc_cnt_reg   <= 64'd0;
            ins_cnt_reg   <= 64'd0;
        end else begin
            state_reg <= state_next;
            if (entering_wait)
                tmo_reg <= 16'd0;
            else if (waiting)
                tmo_reg <= tmo_reg + 16'd1;
            // Strobes come straight from flops, decoded from the upcoming state
            ifu_req_reg   <= (state_next == S_IF);
            idu_ready_reg <= (state_next == S_ID);
            exu_ready_reg <= (state_next == S_EX);
            wbu_ready_reg <= (state_next == S_WB);
            lsu_req_reg   <= (state_next == S_MA);
            halt_reg      <= (state_next == S_HALT);
            err_reg       <= err_reg | err_next;
            if ((state_reg != S_IDLE) && (state_reg != S_HALT))
                cyc_cnt_reg <= cyc_cnt_reg + 64'd1;
            if (state_reg == S_WB)
                ins_cnt_reg <= ins_cnt_reg + 64'd1;
        end
    end

    assign o_ifu_req   = ifu_req_reg;
    assign o_idu_ready = idu_ready_reg;
    assign o_exu_ready = exu_ready_reg;
    assign o_wbu_ready = wbu_ready_reg;
    assign o_lsu_req   = lsu_req_reg;
    assign o_pc_wr_en  = wbu_ready_reg;
    assign o_gpr_wr_en = wbu_ready_reg & i_ctr_reg_wr_en;
    assign o_halt      = halt_reg;
    assign o_err       = err_reg;
    assign o_cyc_cnt   = cyc_cnt_reg;
    assign o_ins_cnt   = ins_cnt_reg;

endmodule

// File: tb/tb_ctl_fsm.sv
// Directed-vector bench for ctl_fsm, run with a 4-cycle fetch/memory timeout.
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 3
`endif
`ifndef REG_WR_SRC_MEM
`define REG_WR_SRC_MEM 1
`endif

module tb_ctl_fsm;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   run, ifu_rsp, lsu_rsp, ram_wr, reg_wr_en, ebreak;
    logic [`ARGS_WIDTH-1:0] wr_src;
    logic                   ifu_req, idu_ready, exu_ready, wbu_ready, lsu_req;
    logic                   gpr_wr_en, pc_wr_en, halt, err;
    logic [63:0]            cyc_cnt, ins_cnt;
    logic [8:0]             outs;

    int vectors = 0;
    int miscompares = 0;

    // {ifu_req, idu, exu, lsu_req, wbu, gpr_wr, pc_wr, halt, err}
    localparam logic [8:0] O_IDLE = 9'b000000000;
    localparam logic [8:0] O_IF   = 9'b100000000;
    localparam logic [8:0] O_ID   = 9'b010000000;
    localparam logic [8:0] O_EX   = 9'b001000000;
    localparam logic [8:0] O_MA   = 9'b000100000;
    localparam logic [8:0] O_WB   = 9'b000010100;
    localparam logic [8:0] O_WBG  = 9'b000011100;
    localparam logic [8:0] O_HALT = 9'b000000010;
    localparam logic [8:0] O_ERR  = 9'b000000011;

    always #5 clk = ~clk;

    ctl_fsm #(.TMO_CYCLES(4)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_run           (run),
        .i_ifu_rsp_valid (ifu_rsp),
        .i_lsu_rsp_valid (lsu_rsp),
        .i_ctr_ram_wr_en (ram_wr),
        .i_ctr_reg_wr_src(wr_src),
        .i_ctr_reg_wr_en (reg_wr_en),
        .i_inst_ebreak   (ebreak),
        .o_ifu_req       (ifu_req),
        .o_idu_ready     (idu_ready),
        .o_exu_ready     (exu_ready),
        .o_wbu_ready     (wbu_ready),
        .o_lsu_req       (lsu_req),
        .o_gpr_wr_en     (gpr_wr_en),
        .o_pc_wr_en      (pc_wr_en),
        .o_halt          (halt),
        .o_err           (err),
        .o_cyc_cnt       (cyc_cnt),
        .o_ins_cnt       (ins_cnt)
    );

    assign outs = {ifu_req, idu_ready, exu_ready, lsu_req, wbu_ready, gpr_wr_en, pc_wr_en, halt, err};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
    endtask

    task automatic chk_state(input string tag, input logic [8:0] exp_o,
                             input logic [63:0] exp_cyc, input logic [63:0] exp_ins);
        chk({tag, ".outs"}, 64'(outs), 64'(exp_o));
        chk({tag, ".cyc"}, cyc_cnt, exp_cyc);
        chk({tag, ".ins"}, ins_cnt, exp_ins);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; ifu_rsp = 1'b0; lsu_rsp = 1'b0;
        ram_wr = 1'b0; reg_wr_en = 1'b0; ebreak = 1'b0; wr_src = '0;
        step(); step();
        chk_state("reset", O_IDLE, 64'd0, 64'd0);
        rst_n = 1'b1;
        step();
        chk_state("idle_hold", O_IDLE, 64'd0, 64'd0);

        // Three ALU instructions with zero-wait fetch
        run = 1'b1; ifu_rsp = 1'b1; reg_wr_en = 1'b1;
        step();
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_state("alu_if", O_IF, 64'(4 * i), 64'(i));
            step(); chk_state("alu_id", O_ID, 64'(4 * i + 1), 64'(i));
            step(); chk_state("alu_ex", O_EX, 64'(4 * i + 2), 64'(i));
            step(); chk_state("alu_wb", O_WBG, 64'(4 * i + 3), 64'(i));
            step();
        end
        chk_state("alu_done", O_IF, 64'd12, 64'd3);

        // Load, data response withheld for three MA cycles
        wr_src = `ARGS_WIDTH'(`REG_WR_SRC_MEM);
        step(); chk_state("ld_id", O_ID, 64'd13, 64'd3);
        ifu_rsp = 1'b0;
        step(); chk_state("ld_ex", O_EX, 64'd14, 64'd3);
        for (int c = 0; c < 4; c++) begin
            step(); chk_state("ld_ma", O_MA, 64'(15 + c), 64'd3);
        end
        lsu_rsp = 1'b1;
        step(); chk_state("ld_wb", O_WBG, 64'd19, 64'd3);
        lsu_rsp = 1'b0; ifu_rsp = 1'b1;
        step(); chk_state("ld_next_if", O_IF, 64'd20, 64'd4);

        // Store without GPR write; early lsu response during IF must be ignored
        wr_src = '0; ram_wr = 1'b1; reg_wr_en = 1'b0; lsu_rsp = 1'b1;
        step(); chk_state("st_id", O_ID, 64'd21, 64'd4);
        step(); chk_state("st_ex", O_EX, 64'd22, 64'd4);
        step(); chk_state("st_ma", O_MA, 64'd23, 64'd4);
        step(); chk_state("st_wb", O_WB, 64'd24, 64'd4);
        lsu_rsp = 1'b0; ram_wr = 1'b0;
        step(); chk_state("st_next_if", O_IF, 64'd25, 64'd5);

        // EBREAK halts without retiring
        ebreak = 1'b1; reg_wr_en = 1'b1;
        step(); chk_state("eb_id", O_ID, 64'd26, 64'd5);
        step(); chk_state("eb_ex", O_EX, 64'd27, 64'd5);
        step(); chk_state("eb_halt", O_HALT, 64'd28, 64'd5);
        run = 1'b1;
        step(); step(); step();
        chk_state("eb_frozen", O_HALT, 64'd28, 64'd5);
        run = 1'b0; ebreak = 1'b0;

        // Fetch timeout: response never arrives
        rst_n = 1'b0; ifu_rsp = 1'b0; reg_wr_en = 1'b0;
        step();
        chk_state("tmo_reset", O_IDLE, 64'd0, 64'd0);
        rst_n = 1'b1; run = 1'b1;
        step();
        run = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk_state("tmo_if", O_IF, 64'(c), 64'd0);
            step();
        end
        chk_state("tmo_halt", O_ERR, 64'd5, 64'd0);
        step();
        chk_state("tmo_sticky", O_ERR, 64'd5, 64'd0);

        // Response in the final allowed IF cycle wins over the timeout
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; run = 1'b1;
        step();
        run = 1'b0;
        for (int c = 0; c < 4; c++) step();
        chk_state("edge_if5", O_IF, 64'd4, 64'd0);
        ifu_rsp = 1'b1; wr_src = `ARGS_WIDTH'(`REG_WR_SRC_MEM);
        step(); chk_state("edge_id", O_ID, 64'd5, 64'd0);
        ifu_rsp = 1'b0;
        step(); chk_state("edge_ex", O_EX, 64'd6, 64'd0);
        step(); chk_state("edge_ma", O_MA, 64'd7, 64'd0);

        // Asynchronous reset during MA clears without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", O_IDLE, 64'd0, 64'd0);
        step();
        rst_n = 1'b1; wr_src = '0;
        step();
        chk_state("post_rst_idle", O_IDLE, 64'd0, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
